// File: rtl/regfile_pkg.sv
// Constants shared between the register file and its write-port arbiter.
package regfile_pkg;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int NREG = 16;

    // Number of requesters the arbiter is usually built with.
    localparam int NREQ_DEFAULT = 4;

endpackage

// File: rtl/regfile_wr_arb_rr_pick.sv
// Rotating-priority find-first: the first unmasked request at or after ptr wins.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic [NREQ-1:0] mask_in,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    logic [NREQ-1:0] w_eff;

    assign w_eff = req & ~mask_in;

    always_comb begin
        logic found;
        int   j;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && w_eff[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Two-port register-file write arbiter: round-robin grant of up to two
// requesters per cycle to distinct registers, with registered write ports.
module regfile_wr_arb #(
    parameter int NREQ = regfile_pkg::NREQ_DEFAULT,
    parameter int AW   = regfile_pkg::AW,
    parameter int DW   = regfile_pkg::DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_sel,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr1_en,
    output logic [AW-1:0]        wr1_sel,
    output logic [DW-1:0]        wr1_data,
    output logic                 wr2_en,
    output logic [AW-1:0]        wr2_sel,
    output logic [DW-1:0]        wr2_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
    endfunction

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0] w_avail;
    logic [NREQ-1:0] w_g1;
    logic [NREQ-1:0] w_g2;
    logic [PW-1:0]   w_idx1;
    logic [PW-1:0]   w_idx2;
    logic [NREQ-1:0] w_mask2;
    logic [AW-1:0]   w_sel1;
    logic [AW-1:0]   w_sel2;
    logic [DW-1:0]   w_data1;
    logic [DW-1:0]   w_data2;

    logic            r_wr1_en;
    logic [AW-1:0]   r_wr1_sel;
    logic [DW-1:0]   r_wr1_data;
    logic            r_wr2_en;
    logic [AW-1:0]   r_wr2_sel;
    logic [DW-1:0]   r_wr2_data;

    // Grants are suppressed while stalled and while reset is asserted.
    assign w_avail = (hold || rst) ? '0 : req_valid;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick1 (
        .req     (w_avail),
        .ptr     (r_ptr),
        .mask_in ('0),
        .grant   (w_g1),
        .idx     (w_idx1)
    );

    assign w_sel1  = req_sel[w_idx1*AW +: AW];
    assign w_data1 = req_data[w_idx1*DW +: DW];

    // Port 2 must not collide with port 1's register, so same-sel requesters sit out.
    always_comb begin
        w_mask2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_mask2[i] = w_g1[i] | (req_sel[i*AW +: AW] == w_sel1);
        end
    end

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick2 (
        .req     (w_avail),
        .ptr     (r_ptr),
        .mask_in (w_mask2),
        .grant   (w_g2),
        .idx     (w_idx2)
    );

    assign w_sel2    = req_sel[w_idx2*AW +: AW];
    assign w_data2   = req_data[w_idx2*DW +: DW];
    assign req_ready = w_g1 | w_g2;

    // Port 2's winner always lies later in scan order than port 1's.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (|w_g2) begin
            w_ptr_nxt = ptr_inc(w_idx2);
        end else if (|w_g1) begin
            w_ptr_nxt = ptr_inc(w_idx1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_wr1_en   <= 1'b0;
            r_wr1_sel  <= '0;
            r_wr1_data <= '0;
            r_wr2_en   <= 1'b0;
            r_wr2_sel  <= '0;
            r_wr2_data <= '0;
        end else begin
            r_ptr    <= w_ptr_nxt;
            r_wr1_en <= |w_g1;
            r_wr2_en <= |w_g2;
            if (|w_g1) begin
                r_wr1_sel  <= w_sel1;
                r_wr1_data <= w_data1;
            end
            if (|w_g2) begin
                r_wr2_sel  <= w_sel2;
                r_wr2_data <= w_data2;
            end
        end
    end

    assign wr1_en   = r_wr1_en;
    assign wr1_sel  = r_wr1_sel;
    assign wr1_data = r_wr1_data;
    assign wr2_en   = r_wr2_en;
    assign wr2_sel  = r_wr2_sel;
    assign wr2_data = r_wr2_data;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed self-checking bench for regfile_wr_arb (NREQ=4, AW=4, DW=16).
module tb_regfile_wr_arb;

    localparam int NREQ = 4;
    localparam int AW   = 4;
    localparam int DW   = 16;

    logic               clk;
    logic               rst;
    logic               hold;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_sel;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr1_en;
    logic [AW-1:0]      wr1_sel;
    logic [DW-1:0]      wr1_data;
    logic               wr2_en;
    logic [AW-1:0]      wr2_sel;
    logic [DW-1:0]      wr2_data;

    int n_pass  = 0;
    int n_total = 0;

    regfile_wr_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr1_en    (wr1_en),
        .wr1_sel   (wr1_sel),
        .wr1_data  (wr1_data),
        .wr2_en    (wr2_en),
        .wr2_sel   (wr2_sel),
        .wr2_data  (wr2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] s, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_sel[i*AW +: AW]  = s;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag,
                            input logic e1, input logic [AW-1:0] s1, input logic [DW-1:0] d1,
                            input logic e2, input logic [AW-1:0] s2, input logic [DW-1:0] d2);
        check({tag, ".wr1_en"},   32'(wr1_en),   32'(e1));
        check({tag, ".wr1_sel"},  32'(wr1_sel),  32'(s1));
        check({tag, ".wr1_data"}, 32'(wr1_data), 32'(d1));
        check({tag, ".wr2_en"},   32'(wr2_en),   32'(e2));
        check({tag, ".wr2_sel"},  32'(wr2_sel),  32'(s2));
        check({tag, ".wr2_data"}, 32'(wr2_data), 32'(d2));
    endtask

    initial begin
        logic [NREQ-1:0] granted;

        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_sel   = '0;
        req_data  = '0;

        // Reset state, with a request pending to prove ready is gated.
        set_req(0, 1'b1, 4'd3, 16'h5555);
        tick();
        tick();
        #1;
        check("rst.ready", 32'(req_ready), 32'h0);
        check("rst.ptr", 32'(dut.r_ptr), 32'h0);
        check_wr("rst", 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0);

        // Two requesters with distinct registers: both ports granted.
        set_req(0, 1'b1, 4'd1, 16'hDEAD);
        set_req(1, 1'b1, 4'd2, 16'hBEEF);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("pair.ready", 32'(req_ready), 32'b0011);
        tick();
        check_wr("pair", 1'b1, 4'd1, 16'hDEAD, 1'b1, 4'd2, 16'hBEEF);
        check("pair.ptr", 32'(dut.r_ptr), 32'd2);

        // Stall for three cycles with req3 waiting; write ports keep old fields.
        set_req(0, 1'b0, 4'd1, 16'hDEAD);
        set_req(1, 1'b0, 4'd2, 16'hBEEF);
        set_req(3, 1'b1, 4'd6, 16'h3333);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold%0d.ready", c), 32'(req_ready), 32'h0);
            tick();
            check_wr($sformatf("hold%0d", c), 1'b0, 4'd1, 16'hDEAD, 1'b0, 4'd2, 16'hBEEF);
            check($sformatf("hold%0d.ptr", c), 32'(dut.r_ptr), 32'd2);
        end
        hold = 1'b0;
        #1;
        check("unhold.ready", 32'(req_ready), 32'b1000);
        tick();
        check_wr("unhold", 1'b1, 4'd6, 16'h3333, 1'b0, 4'd2, 16'hBEEF);
        check("unhold.ptr", 32'(dut.r_ptr), 32'd0);

        // Same-register conflict: req0 first, req2 waits a cycle.
        set_req(3, 1'b0, 4'd6, 16'h3333);
        set_req(0, 1'b1, 4'd5, 16'h1111);
        set_req(2, 1'b1, 4'd5, 16'h2222);
        #1;
        check("conf1.ready", 32'(req_ready), 32'b0001);
        tick();
        check_wr("conf1", 1'b1, 4'd5, 16'h1111, 1'b0, 4'd2, 16'hBEEF);
        set_req(0, 1'b0, 4'd5, 16'h1111);
        #1;
        check("conf2.ready", 32'(req_ready), 32'b0100);
        tick();
        check_wr("conf2", 1'b1, 4'd5, 16'h2222, 1'b0, 4'd2, 16'hBEEF);

        // Single requester: port 1 only, ptr follows it.
        set_req(2, 1'b1, 4'd4, 16'h1234);
        #1;
        check("single.ready", 32'(req_ready), 32'b0100);
        tick();
        check_wr("single", 1'b1, 4'd4, 16'h1234, 1'b0, 4'd2, 16'hBEEF);
        check("single.ptr", 32'(dut.r_ptr), 32'd3);

        // Reset pulse right after a write lands: outputs clear without a clock edge.
        set_req(2, 1'b0, 4'd4, 16'h1234);
        set_req(1, 1'b1, 4'd7, 16'h7777);
        tick();
        check("midrst.pre_en", 32'(wr1_en), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check_wr("midrst", 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0);
        check("midrst.ptr", 32'(dut.r_ptr), 32'd0);
        check("midrst.ready", 32'(req_ready), 32'h0);
        set_req(1, 1'b0, 4'd7, 16'h7777);
        tick();
        @(negedge clk);
        rst = 1'b0;

        // All four valid with distinct registers: pairs {0,1},{2,3} repeating.
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b1, AW'(8 + i), DW'(16'hA000 + i));
        end
        granted = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("all%0d.ready", c), 32'(req_ready), (c % 2 == 0) ? 32'b0011 : 32'b1100);
            granted = granted | req_ready;
            tick();
            if (c % 2 == 0) begin
                check_wr($sformatf("all%0d", c), 1'b1, 4'd8, 16'hA000, 1'b1, 4'd9, 16'hA001);
            end else begin
                check_wr($sformatf("all%0d", c), 1'b1, 4'd10, 16'hA002, 1'b1, 4'd11, 16'hA003);
            end
        end
        check("all.starve", 32'(granted), 32'b1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
